// File: rtl/vga_mem_arb.sv
// Round-robin arbiter for the core-side port of the VGA frame buffer, with a
// highest-priority clear/fill engine that writes one constant word to every location.

module vga_mem_arb_lane #(
   parameter int MEM_WORDS = 9600,
   parameter int ADDR_W    = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              gnt,
   input  logic              wr_en,
   output logic              in_range,
   output logic              rsp_vld,
   output logic              rsp_err
);
   // One extra bit so MEM_WORDS == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] LIMIT = MEM_WORDS[ADDR_W:0];

   assign in_range = {1'b0, addr} < LIMIT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_vld <= 1'b0;
         rsp_err <= 1'b0;
      end else begin
         rsp_vld <= gnt & ~wr_en;
         rsp_err <= gnt & ~wr_en & ~in_range;
      end
   end
endmodule

module vga_mem_arb #(
   parameter int NUM_REQ   = 4,
   parameter int MEM_WORDS = 9600,
   parameter int ADDR_W    = 14
) (
   input  logic                           QClk,
   input  logic                           Reset,
   input  logic [NUM_REQ-1:0]             ReqValid,
   input  logic [NUM_REQ-1:0]             ReqWrEn,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] ReqAddr,
   input  logic [NUM_REQ-1:0][31:0]       ReqData,
   input  logic [NUM_REQ-1:0][3:0]        ReqByteEn,
   output logic [NUM_REQ-1:0]             ReqReady,
   output logic [NUM_REQ-1:0]             RspValid,
   output logic [31:0]                    RspData,
   output logic                           AddrErr,
   input  logic                           ClearStart,
   input  logic [31:0]                    ClearData,
   output logic                           ClearBusy,
   output logic                           ClearDone,
   output logic                           MemWrEn,
   output logic                           MemRdEn,
   output logic [ADDR_W-1:0]              MemAddr,
   output logic [31:0]                    MemWrData,
   output logic [3:0]                     MemByteEn,
   input  logic [31:0]                    MemRdData
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(MEM_WORDS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        be;
   } req_t;

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  fill_cnt, fill_cnt_nxt;
   logic [31:0]        fill_word, fill_word_nxt;
   logic [IDX_W-1:0]   last_gnt, last_gnt_nxt;
   logic               done_nxt;
   logic               rr_hit;
   logic [IDX_W-1:0]   rr_idx;
   int                 rr_j;
   req_t               sel;
   logic [NUM_REQ-1:0] in_range;
   logic [NUM_REQ-1:0] rsp_err;

   // Rotating priority search starting just after the last winner.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      rr_j   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_j = (int'(last_gnt) + k) % NUM_REQ;
         if (!rr_hit && ReqValid[rr_j[IDX_W-1:0]]) begin
            rr_hit = 1'b1;
            rr_idx = rr_j[IDX_W-1:0];
         end
      end
   end

   assign sel = '{wr:   ReqWrEn[rr_idx],
                  addr: ReqAddr[rr_idx],
                  data: ReqData[rr_idx],
                  be:   ReqByteEn[rr_idx]};

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      vga_mem_arb_lane #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) u_lane (
         .clk      (QClk),
         .rst      (Reset),
         .addr     (ReqAddr[i]),
         .gnt      (ReqReady[i]),
         .wr_en    (ReqWrEn[i]),
         .in_range (in_range[i]),
         .rsp_vld  (RspValid[i]),
         .rsp_err  (rsp_err[i])
      );
   end

   // Out-of-range reads still answer, but with a zero word.
   assign RspData   = (|RspValid && !(|rsp_err)) ? MemRdData : 32'h0;
   assign ClearBusy = (state == CLEAR);

   always_comb begin
      state_nxt     = state;
      fill_cnt_nxt  = fill_cnt;
      fill_word_nxt = fill_word;
      last_gnt_nxt  = last_gnt;
      done_nxt      = 1'b0;
      ReqReady      = '0;
      AddrErr       = 1'b0;
      MemWrEn       = 1'b0;
      MemRdEn       = 1'b0;
      MemAddr       = '0;
      MemWrData     = '0;
      MemByteEn     = '0;
      // Combinational outputs are held low while reset is asserted.
      if (!Reset) begin
         case (state)
            IDLE: begin
               if (ClearStart) begin
                  state_nxt     = CLEAR;
                  fill_cnt_nxt  = '0;
                  fill_word_nxt = ClearData;
               end else if (rr_hit) begin
                  ReqReady[rr_idx] = 1'b1;
                  last_gnt_nxt     = rr_idx;
                  if (in_range[rr_idx]) begin
                     MemWrEn = sel.wr;
                     MemRdEn = ~sel.wr;
                     MemAddr = sel.addr;
                     if (sel.wr) begin
                        MemWrData = sel.data;
                        MemByteEn = sel.be;
                     end
                  end else begin
                     AddrErr = 1'b1;
                  end
               end
            end
            CLEAR: begin
               MemWrEn   = 1'b1;
               MemAddr   = fill_cnt;
               MemWrData = fill_word;
               MemByteEn = 4'hF;
               if (fill_cnt == FILL_LAST) begin
                  state_nxt    = IDLE;
                  fill_cnt_nxt = '0;
                  done_nxt     = 1'b1;
               end else begin
                  fill_cnt_nxt = fill_cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge QClk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         fill_cnt  <= '0;
         fill_word <= '0;
         last_gnt  <= IDX_W'(NUM_REQ - 1);
         ClearDone <= 1'b0;
      end else begin
         state     <= state_nxt;
         fill_cnt  <= fill_cnt_nxt;
         fill_word <= fill_word_nxt;
         last_gnt  <= last_gnt_nxt;
         ClearDone <= done_nxt;
      end
   end
endmodule

// File: tb/tb_vga_mem_arb.sv
// Bench for vga_mem_arb: vector table, directed fill/reset sequences and random
// traffic, all checked against a cycle-level reference model and a RAM model.

module tb_vga_mem_arb;
   localparam int NR = 4;
   localparam int MW = 9600;
   localparam int AW = 14;

   logic                   QClk = 1'b0;
   logic                   Reset;
   logic [NR-1:0]          ReqValid, ReqWrEn, ReqReady, RspValid;
   logic [NR-1:0][AW-1:0]  ReqAddr;
   logic [NR-1:0][31:0]    ReqData;
   logic [NR-1:0][3:0]     ReqByteEn;
   logic [31:0]            RspData, ClearData, MemWrData, MemRdData;
   logic                   AddrErr, ClearStart, ClearBusy, ClearDone, MemWrEn, MemRdEn;
   logic [AW-1:0]          MemAddr;
   logic [3:0]             MemByteEn;

   int checks = 0;
   int errors = 0;

   vga_mem_arb #(.NUM_REQ(NR), .MEM_WORDS(MW), .ADDR_W(AW)) dut (
      .QClk(QClk), .Reset(Reset), .ReqValid(ReqValid), .ReqWrEn(ReqWrEn),
      .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqByteEn(ReqByteEn),
      .ReqReady(ReqReady), .RspValid(RspValid), .RspData(RspData), .AddrErr(AddrErr),
      .ClearStart(ClearStart), .ClearData(ClearData), .ClearBusy(ClearBusy),
      .ClearDone(ClearDone), .MemWrEn(MemWrEn), .MemRdEn(MemRdEn), .MemAddr(MemAddr),
      .MemWrData(MemWrData), .MemByteEn(MemByteEn), .MemRdData(MemRdData)
   );

   always #5 QClk = ~QClk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-buffer RAM seen by the DUT: 1-cycle read latency, byte-enabled writes.
   logic [31:0] ram [MW];
   always @(posedge QClk) begin
      if (MemWrEn && int'(MemAddr) < MW)
         for (int b = 0; b < 4; b++)
            if (MemByteEn[b]) ram[MemAddr][8*b +: 8] <= MemWrData[8*b +: 8];
      if (MemRdEn && int'(MemAddr) < MW) MemRdData <= ram[MemAddr];
      else                               MemRdData <= $urandom;
   end

   // Reference model: what the arbiter should do this cycle, from the rules.
   logic [31:0] ref_mem [MW];
   logic        m_clr, m_pend, m_done;
   int          m_fill, m_last, m_w, m_pend_who;
   logic [31:0] m_word, m_pend_data;
   logic [NR-1:0] m_gnt;
   logic [NR-1:0] e_rdy, e_rsp;
   logic        e_we, e_re, e_err, e_busy, e_done;
   logic [AW-1:0] e_addr;
   logic [31:0] e_wd, e_rd;
   logic [3:0]  e_be;

   always @(negedge QClk) begin
      e_rdy = '0; e_rsp = '0; e_we = 0; e_re = 0; e_err = 0; e_busy = 0; e_done = 0;
      e_addr = '0; e_wd = '0; e_rd = '0; e_be = '0;
      if (Reset) begin
         m_clr = 0; m_fill = 0; m_last = NR - 1; m_pend = 0; m_done = 0;
      end else begin
         e_busy = m_clr;
         e_done = m_done;
         if (m_pend) begin e_rsp[m_pend_who] = 1'b1; e_rd = m_pend_data; end
         m_pend = 0;
         m_done = 0;
         if (m_clr) begin
            e_we = 1; e_addr = AW'(m_fill); e_wd = m_word; e_be = 4'hF;
            ref_mem[m_fill] = m_word;
            m_fill++;
            if (m_fill == MW) begin m_clr = 0; m_done = 1; end
         end else if (ClearStart) begin
            m_clr = 1; m_fill = 0; m_word = ClearData;
         end else begin
            m_w = -1;
            for (int k = 1; k <= NR; k++)
               if (m_w < 0 && ReqValid[(m_last + k) % NR]) m_w = (m_last + k) % NR;
            if (m_w >= 0) begin
               e_rdy[m_w] = 1'b1;
               m_last = m_w;
               if (int'(ReqAddr[m_w]) >= MW) begin
                  e_err = 1;
                  if (!ReqWrEn[m_w]) begin m_pend = 1; m_pend_who = m_w; m_pend_data = 0; end
               end else if (ReqWrEn[m_w]) begin
                  e_we = 1; e_addr = ReqAddr[m_w]; e_wd = ReqData[m_w]; e_be = ReqByteEn[m_w];
                  for (int b = 0; b < 4; b++)
                     if (e_be[b]) ref_mem[ReqAddr[m_w]][8*b +: 8] = e_wd[8*b +: 8];
               end else begin
                  e_re = 1; e_addr = ReqAddr[m_w];
                  m_pend = 1; m_pend_who = m_w; m_pend_data = ref_mem[ReqAddr[m_w]];
               end
            end
         end
      end
      m_gnt = e_rdy;
      check("ctl", {ReqReady, AddrErr, ClearBusy, ClearDone}, {e_rdy, e_err, e_busy, e_done});
      check("mem_bus",
            {MemWrEn, MemRdEn, (MemWrEn | MemRdEn) ? MemAddr : AW'(0),
             MemWrEn ? MemWrData : 32'h0, MemWrEn ? MemByteEn : 4'h0},
            {e_we, e_re, e_addr, e_wd, e_be});
      check("rsp", {RspValid, (|RspValid) ? RspData : 32'h0}, {e_rsp, e_rd});
   end

   typedef struct packed {
      logic [3:0]  vld, wr;
      logic [13:0] addr;
      logic [31:0] data;
      logic [3:0]  be, rdy;
      logic        we, re, err;
      logic [3:0]  rsp;
      logic [31:0] rdata;
   } vec_t;
   vec_t tbl [18];

   task automatic drive_all(input logic [3:0] vld, input logic [3:0] wr, input logic [13:0] a,
                            input logic [31:0] d, input logic [3:0] be);
      ReqValid = vld; ReqWrEn = wr;
      for (int r = 0; r < NR; r++) begin ReqAddr[r] = a; ReqData[r] = d; ReqByteEn[r] = be; end
   endtask

   task automatic pulse_reset();
      Reset = 1;
      repeat (2) @(posedge QClk);
      #1 Reset = 0;
   endtask

   task automatic run_fill(input logic [31:0] word, input int repulse_at, output int busy,
                           output int done, output int seq_err, output logic [3:0] rdy_done);
      int idx;
      ClearStart = 1; ClearData = word;
      @(negedge QClk);
      check("clr_start_no_grant", {60'h0, ReqReady}, 64'h0);
      @(posedge QClk); #1;
      ClearStart = 0; ClearData = $urandom;
      busy = 0; done = 0; seq_err = 0; idx = 0; rdy_done = '0;
      for (int c = 0; c < MW + 20; c++) begin
         @(negedge QClk);
         if (ClearBusy) begin
            if (!MemWrEn || int'(MemAddr) != idx || MemWrData != word || ReqReady != 0) seq_err++;
            idx++; busy++;
         end
         if (ClearDone) begin done++; rdy_done = ReqReady; end
         @(posedge QClk); #1;
         ClearStart = (c == repulse_at);
         ClearData  = $urandom;
      end
      ClearStart = 0;
   endtask

   initial begin
      int busy, done, seq_err, found, dcnt;
      logic [3:0] rdy_done;
      // addr 5 after fill FFFFFFFF, then written A5A5_0F0F with byte enables 0011
      tbl[0]  = '{4'hF, 4'h0, 14'd100,  32'h0,         4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0};
      tbl[1]  = '{4'hF, 4'h0, 14'd100,  32'h0,         4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 4'h1, 32'hFFFF_FFFF};
      tbl[2]  = '{4'hF, 4'h0, 14'd100,  32'h0,         4'h0, 4'h4, 1'b0, 1'b1, 1'b0, 4'h2, 32'hFFFF_FFFF};
      tbl[3]  = '{4'hF, 4'h0, 14'd100,  32'h0,         4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h4, 32'hFFFF_FFFF};
      tbl[4]  = '{4'hF, 4'h0, 14'd100,  32'h0,         4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 4'h8, 32'hFFFF_FFFF};
      tbl[5]  = '{4'hF, 4'h0, 14'd100,  32'h0,         4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 4'h1, 32'hFFFF_FFFF};
      tbl[6]  = '{4'hF, 4'h0, 14'd100,  32'h0,         4'h0, 4'h4, 1'b0, 1'b1, 1'b0, 4'h2, 32'hFFFF_FFFF};
      tbl[7]  = '{4'hF, 4'h0, 14'd100,  32'h0,         4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h4, 32'hFFFF_FFFF};
      tbl[8]  = '{4'h4, 4'h4, 14'd5,    32'hA5A5_0F0F, 4'h3, 4'h4, 1'b1, 1'b0, 1'b0, 4'h8, 32'hFFFF_FFFF};
      tbl[9]  = '{4'h2, 4'h0, 14'd5,    32'h0,         4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0};
      tbl[10] = '{4'h0, 4'h0, 14'd5,    32'h0,         4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 32'hFFFF_0F0F};
      tbl[11] = '{4'h8, 4'h0, 14'd9600, 32'h0,         4'h0, 4'h8, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0};
      tbl[12] = '{4'h0, 4'h0, 14'd0,    32'h0,         4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h8, 32'h0};
      tbl[13] = '{4'h1, 4'h1, 14'd16383,32'h1234,      4'hF, 4'h1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0};
      tbl[14] = '{4'hA, 4'h0, 14'd5,    32'h0,         4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0};
      tbl[15] = '{4'hA, 4'h0, 14'd5,    32'h0,         4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h2, 32'hFFFF_0F0F};
      tbl[16] = '{4'h3, 4'h0, 14'd5,    32'h0,         4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 4'h8, 32'hFFFF_0F0F};
      tbl[17] = '{4'h0, 4'h0, 14'd5,    32'h0,         4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 32'hFFFF_0F0F};

      Reset = 1; ClearStart = 0; ClearData = '0;
      drive_all(4'hF, 4'h0, 14'd0, 32'h0, 4'h0);
      @(negedge QClk);
      check("reset_outputs", {ReqReady, RspValid, AddrErr, ClearBusy, ClearDone, MemWrEn, MemRdEn},
            64'h0);
      @(posedge QClk); #1 Reset = 0;
      drive_all(4'h0, 4'h0, 14'd0, 32'h0, 4'h0);
      @(posedge QClk); #1;

      // Fill with requester 0 waiting throughout
      drive_all(4'h1, 4'h0, 14'd7, 32'h0, 4'h0);
      run_fill(32'hFFFF_FFFF, -1, busy, done, seq_err, rdy_done);
      check("fill1_busy_cycles", 64'(busy), 64'(MW));
      check("fill1_done_pulses", 64'(done), 64'd1);
      check("fill1_write_seq", 64'(seq_err), 64'd0);
      check("fill1_grant_at_done", {60'h0, rdy_done}, 64'h1);
      drive_all(4'h0, 4'h0, 14'd0, 32'h0, 4'h0);
      @(posedge QClk); #1;

      pulse_reset();
      for (int i = 0; i < 18; i++) begin
         drive_all(tbl[i].vld, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be);
         @(negedge QClk);
         check($sformatf("t%0d_ready", i), {60'h0, ReqReady}, {60'h0, tbl[i].rdy});
         check($sformatf("t%0d_wr_rd_err", i), {61'h0, MemWrEn, MemRdEn, AddrErr},
               {61'h0, tbl[i].we, tbl[i].re, tbl[i].err});
         check($sformatf("t%0d_rsp_valid", i), {60'h0, RspValid}, {60'h0, tbl[i].rsp});
         if (tbl[i].rsp != 0)
            check($sformatf("t%0d_rsp_data", i), {32'h0, RspData}, {32'h0, tbl[i].rdata});
         @(posedge QClk); #1;
      end

      // Second ClearStart during the fill must be ignored
      run_fill(32'h1357_9BDF, 50, busy, done, seq_err, rdy_done);
      check("fill2_busy_cycles", 64'(busy), 64'(MW));
      check("fill2_done_pulses", 64'(done), 64'd1);
      check("fill2_write_seq", 64'(seq_err), 64'd0);

      // Reset landing on fill write 100
      ClearStart = 1; ClearData = 32'h0BAD_F00D;
      @(posedge QClk); #1 ClearStart = 0;
      drive_all(4'h1, 4'h0, 14'd9, 32'h0, 4'h0);
      found = 0;
      for (int c = 0; c < 500 && found == 0; c++) begin
         @(negedge QClk);
         if (MemWrEn && MemAddr == 14'd99) found = 1;
         @(posedge QClk); #1;
      end
      check("fill3_reached_99", 64'(found), 64'd1);
      Reset = 1;
      @(negedge QClk);
      check("midfill_reset_outputs",
            {ReqReady, RspValid, AddrErr, ClearBusy, ClearDone, MemWrEn, MemRdEn, MemAddr},
            64'h0);
      @(posedge QClk); @(posedge QClk); #1 Reset = 0;
      @(negedge QClk);
      check("after_reset_grant", {60'h0, ReqReady}, 64'h1);
      dcnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge QClk);
         if (ClearDone || ClearBusy) dcnt++;
      end
      check("no_done_after_abort", 64'(dcnt), 64'd0);
      @(posedge QClk); #1;

      // Random traffic; a waiting requester holds its fields until granted
      for (int c = 0; c < 3000; c++) begin
         for (int r = 0; r < NR; r++) begin
            if (!(ReqValid[r] && !m_gnt[r])) begin
               ReqValid[r]  = ($urandom_range(0, 99) < 60);
               ReqWrEn[r]   = $urandom_range(0, 1) == 1;
               ReqAddr[r]   = ($urandom_range(0, 9) == 0) ? AW'(MW + $urandom_range(0, 100))
                                                          : AW'($urandom_range(0, MW - 1));
               ReqData[r]   = $urandom;
               ReqByteEn[r] = 4'($urandom_range(0, 15));
            end
         end
         @(posedge QClk); #1;
      end
      drive_all(4'h0, 4'h0, 14'd0, 32'h0, 4'h0);
      repeat (3) @(posedge QClk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
